// File: rtl/mul_arbiter_if.sv
// Handshake bundle between the job arbiter (master) and a shift-add multiplier (slave).
// Signal names keep the multiplier's native mixed-case naming.
interface mul_arbiter_if #(
  parameter int WIDTH = 32
);
  logic                   mul_Reset;
  logic                   mul_Run;
  logic [WIDTH-1:0]       mul_A;
  logic [WIDTH-1:0]       mul_B;
  logic                   mul_Ready;
  logic [2*WIDTH-1:0]     mul_Product;

  modport master (
    output mul_Reset, mul_Run, mul_A, mul_B,
    input  mul_Ready, mul_Product
  );

  modport slave (
    input  mul_Reset, mul_Run, mul_A, mul_B,
    output mul_Ready, mul_Product
  );
endinterface

// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one multi-cycle multiplier between two requesters,
// with a watchdog that abandons jobs whose multiplier never reports ready.
module mul_arbiter #(
  parameter int WIDTH      = 32,
  parameter int MAX_CYCLES = 40
) (
  input  logic                 clk,
  input  logic                 Reset,
  input  logic                 req0,
  input  logic                 req1,
  input  logic [WIDTH-1:0]     a0,
  input  logic [WIDTH-1:0]     b0,
  input  logic [WIDTH-1:0]     a1,
  input  logic [WIDTH-1:0]     b1,
  mul_arbiter_if.master        mul,
  output logic [2*WIDTH-1:0]   result,
  output logic                 done0,
  output logic                 done1,
  output logic                 err,
  output logic                 busy
);

  localparam int             CW      = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0]  MAX_CNT = CW'(MAX_CYCLES);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DONE, ERR} state_e;

  state_e               state_q, state_d;
  logic                 gnt_q, gnt_d;
  logic                 prio_q, prio_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     mul_a_q, mul_a_d;
  logic [WIDTH-1:0]     mul_b_q, mul_b_d;
  logic                 mul_reset_q, mul_reset_d;
  logic                 mul_run_q, mul_run_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 done0_q, done0_d;
  logic                 done1_q, done1_d;
  logic                 err_q, err_d;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d     = state_q;
    gnt_d       = gnt_q;
    prio_d      = prio_q;
    cnt_d       = cnt_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    mul_reset_d = 1'b0;
    mul_run_d   = mul_run_q;
    result_d    = result_q;
    done0_d     = 1'b0;
    done1_d     = 1'b0;
    err_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // prio only matters on contention; a lone request always wins
          gnt_d   = (req0 && req1) ? prio_q : req1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        mul_a_d     = gnt_q ? a1 : a0;
        mul_b_d     = gnt_q ? b1 : b0;
        mul_reset_d = 1'b1;
        mul_run_d   = 1'b0;
        cnt_d       = '0;
        state_d     = RUN;
      end
      RUN: begin
        mul_run_d = 1'b1;
        cnt_d     = cnt_q + CW'(1);
        if (mul.mul_Ready) begin
          result_d = mul.mul_Product;
          state_d  = DONE;
        end else if (cnt_d == MAX_CNT) begin
          state_d  = ERR;
        end
      end
      DONE: begin
        done0_d   = ~gnt_q;
        done1_d   = gnt_q;
        prio_d    = ~gnt_q;
        mul_run_d = 1'b0;
        state_d   = IDLE;
      end
      ERR: begin
        err_d       = 1'b1;
        mul_reset_d = 1'b1;
        mul_run_d   = 1'b0;
        prio_d      = ~gnt_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!Reset) begin
      state_q     <= IDLE;
      gnt_q       <= 1'b0;
      prio_q      <= 1'b0;
      cnt_q       <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      mul_reset_q <= 1'b0;
      mul_run_q   <= 1'b0;
      result_q    <= '0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      prio_q      <= prio_d;
      cnt_q       <= cnt_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      mul_reset_q <= mul_reset_d;
      mul_run_q   <= mul_run_d;
      result_q    <= result_d;
      done0_q     <= done0_d;
      done1_q     <= done1_d;
      err_q       <= err_d;
    end
  end

  assign mul.mul_Reset = mul_reset_q;
  assign mul.mul_Run   = mul_run_q;
  assign mul.mul_A     = mul_a_q;
  assign mul.mul_B     = mul_b_q;
  assign result        = result_q;
  assign done0         = done0_q;
  assign done1         = done1_q;
  assign err           = err_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed bench for mul_arbiter: a behavioural multiplier with programmable
// ready timing, plus hand-computed results, latencies and pulse checks.
module tb_mul_arbiter;

  logic        clk = 1'b0;
  logic        Reset;
  logic        req0, req1;
  logic [31:0] a0, b0, a1, b1;
  logic [63:0] result;
  logic        done0, done1, err, busy;

  logic        ready_force;
  logic        model_en;
  int          ready_cycle;
  int          cnt_m;

  int passed = 0;
  int total  = 0;

  int          lat;
  logic        d0, d1, e;
  int          busy_low;

  mul_arbiter_if #(.WIDTH(32)) mif ();

  mul_arbiter #(.WIDTH(32), .MAX_CYCLES(40)) dut (
    .clk    (clk),
    .Reset  (Reset),
    .req0   (req0),
    .req1   (req1),
    .a0     (a0),
    .b0     (b0),
    .a1     (a1),
    .b1     (b1),
    .mul    (mif),
    .result (result),
    .done0  (done0),
    .done1  (done1),
    .err    (err),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  // Multiplier model: counts mul_Run cycles since the last mul_Reset. mul_Run
  // rises one cycle into RUN, so ready in arbiter RUN cycle n needs n-2 counts.
  always @(posedge clk) begin
    if (mif.mul_Reset)    cnt_m <= 0;
    else if (mif.mul_Run) cnt_m <= cnt_m + 1;
  end
  assign mif.mul_Product = {32'b0, mif.mul_A} * {32'b0, mif.mul_B};
  assign mif.mul_Ready   = ready_force |
                           (model_en & mif.mul_Run & (cnt_m == ready_cycle - 2));

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 100000");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Called one negedge after the granting edge; lat counts edges from that edge.
  // At iteration drop_at all requests drop and operands change.
  task automatic run_job(input int drop_at, output int lat_o, output logic d0_o,
                         output logic d1_o, output logic e_o, output int busy_low_o);
    lat_o = -1; d0_o = 0; d1_o = 0; e_o = 0; busy_low_o = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (done0 || done1 || err) begin
        lat_o = i; d0_o = done0; d1_o = done1; e_o = err;
        return;
      end
      if (!busy) busy_low_o++;
      if (i == drop_at) begin
        req0 = 1'b0; req1 = 1'b0;
        a0 = a0 + 32'd1; a1 = a1 + 32'd1;
      end
    end
  endtask

  initial begin
    Reset = 1'b0; req0 = 0; req1 = 0;
    a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    ready_force = 0; model_en = 1; ready_cycle = 32;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy",      busy, 0);
    check("rst_result",    result, 0);
    check("rst_done0",     done0, 0);
    check("rst_done1",     done1, 0);
    check("rst_err",       err, 0);
    check("rst_mul_run",   mif.mul_Run, 0);
    check("rst_mul_reset", mif.mul_Reset, 0);
    check("rst_mul_a",     mif.mul_A, 0);
    Reset = 1'b1;
    @(negedge clk);

    // Single job 3*5, ready in RUN cycle 32 -> done 34 edges after grant
    req0 = 1; a0 = 3; b0 = 5;
    @(negedge clk);
    run_job(1, lat, d0, d1, e, busy_low);
    check("t1_latency",  lat, 34);
    check("t1_done0",    d0, 1);
    check("t1_done1",    d1, 0);
    check("t1_err",      e, 0);
    check("t1_busy_job", busy_low, 0);
    check("t1_result",   result, 15);
    @(negedge clk);
    check("t1_done0_single", done0, 0);
    check("t1_busy_idle",    busy, 0);

    // mul_Ready outside RUN is ignored
    ready_force = 1;
    repeat (2) @(negedge clk);
    ready_force = 0;
    check("idle_ready_busy",   busy, 0);
    check("idle_ready_result", result, 15);
    check("idle_ready_done",   {done0, done1, err}, 0);

    // Continuous contention alternates, starting with req0 after reset
    Reset = 0; @(negedge clk); Reset = 1;
    check("rr_reset_result", result, 0);
    ready_cycle = 5;
    a0 = 2; b0 = 7; a1 = 4; b1 = 9; req0 = 1; req1 = 1;
    @(negedge clk);
    run_job(0, lat, d0, d1, e, busy_low);
    check("rr1_done0",  d0, 1);
    check("rr1_done1",  d1, 0);
    check("rr1_result", result, 14);
    check("rr1_latency", lat, 7);
    @(negedge clk);
    run_job(0, lat, d0, d1, e, busy_low);
    check("rr2_done0",  d0, 0);
    check("rr2_done1",  d1, 1);
    check("rr2_result", result, 36);
    @(negedge clk);
    run_job(0, lat, d0, d1, e, busy_low);
    req0 = 0; req1 = 0;
    check("rr3_done0",  d0, 1);
    check("rr3_done1",  d1, 0);
    check("rr3_result", result, 14);

    // Watchdog: ready never rises -> err after 40 RUN cycles
    model_en = 0;
    req1 = 1; a1 = 11; b1 = 13;
    @(negedge clk);
    run_job(1, lat, d0, d1, e, busy_low);
    check("wd_latency",   lat, 42);
    check("wd_err",       e, 1);
    check("wd_no_done",   {d0, d1}, 0);
    check("wd_mul_reset", mif.mul_Reset, 1);
    check("wd_result",    result, 14);
    @(negedge clk);
    check("wd_err_single",  err, 0);
    check("wd_mul_reset_0", mif.mul_Reset, 0);

    // Request dropped and operand changed mid-RUN: job still completes
    model_en = 1; ready_cycle = 10;
    req1 = 1; a1 = 6; b1 = 7;
    @(negedge clk);
    run_job(3, lat, d0, d1, e, busy_low);
    check("drop_done1",   d1, 1);
    check("drop_result",  result, 42);
    check("drop_latency", lat, 12);

    // Ready on the same cycle the watchdog expires: ready wins
    ready_cycle = 40;
    req0 = 1; a0 = 12; b0 = 12;
    @(negedge clk);
    run_job(1, lat, d0, d1, e, busy_low);
    check("race_done0",   d0, 1);
    check("race_err",     e, 0);
    check("race_result",  result, 144);
    check("race_latency", lat, 42);

    // Reset mid-RUN abandons the job; first grant afterwards goes to req0
    ready_cycle = 32;
    req0 = 1; a0 = 5; b0 = 5;
    @(negedge clk);
    req0 = 0;
    repeat (5) @(negedge clk);
    check("mid_run_active", mif.mul_Run, 1);
    Reset = 0;
    @(negedge clk);
    check("mid_rst_busy",    busy, 0);
    check("mid_rst_mul_run", mif.mul_Run, 0);
    check("mid_rst_result",  result, 0);
    check("mid_rst_pulses",  {done0, done1, err}, 0);
    Reset = 1; ready_cycle = 5;
    a0 = 3; b0 = 3; a1 = 4; b1 = 4; req0 = 1; req1 = 1;
    @(negedge clk);
    run_job(1, lat, d0, d1, e, busy_low);
    check("post_rst_done0",  d0, 1);
    check("post_rst_done1",  d1, 0);
    check("post_rst_result", result, 9);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 Parameter: WIDTH, default 32, operand width; product width is 2*WIDTH.
REQ-002 Parameter: MAX_CYCLES, default 40, watchdog limit in RUN cycles before a multiplier job is abandoned.
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: Reset  input  1  synchronous, active-low reset.
REQ-005 Port: req0, req1  input  1 each  requester job requests, level-sensitive.
REQ-006 Port: a0, b0, a1, b1  input  WIDTH each  multiplicand and multiplier operands of requesters 0 and 1.
REQ-007 Port: mul_Reset  output  1  active-high load/clear strobe to the shift-add multiplier.
REQ-008 Port: mul_Run  output  1  run enable to the multiplier.
REQ-009 Port: mul_A, mul_B  output  WIDTH each  operands driven to the multiplier.
REQ-010 Port: mul_Ready  input  1  multiplier completion flag.
REQ-011 Port: mul_Product  input  2*WIDTH  multiplier result.
REQ-012 Port: result  output  2*WIDTH  registered product of the most recently completed job.
REQ-013 Port: done0, done1  output  1 each  one-cycle completion pulse per requester.
REQ-014 Port: err  output  1  one-cycle watchdog timeout pulse.
REQ-015 Port: busy  output  1  high in every state except IDLE.

Function
REQ-016 States SHALL be: IDLE, LOAD, RUN, DONE, ERR.
REQ-017 IDLE: if either request is high, SHALL register grant (gnt) and go to LOAD; if neither is high, SHALL stay in IDLE.
REQ-018 Arbitration SHALL be round-robin: pointer prio selects the winner when both requests are high; a single request wins regardless of prio.
REQ-019 LOAD (1 cycle): SHALL latch a_gnt/b_gnt into mul_A/mul_B, assert mul_Reset=1 and mul_Run=0, clear the watchdog counter, and go to RUN.
REQ-020 Operand changes after LOAD SHALL be ignored until the next LOAD.
REQ-021 RUN: SHALL hold mul_Run=1 and mul_Reset=0, and increment the watchdog counter each cycle.
REQ-022 RUN with mul_Ready=1 sampled: SHALL capture mul_Product into result and go to DONE.
REQ-023 RUN with counter reaching MAX_CYCLES and mul_Ready=0: SHALL go to ERR.
REQ-024 If mul_Ready and the timeout occur in the same cycle, mul_Ready SHALL win.
REQ-025 DONE (1 cycle): SHALL assert done_gnt=1, set prio to the non-granted requester, drive mul_Run=0, and return to IDLE.
REQ-026 ERR (1 cycle): SHALL assert err=1 and mul_Reset=1, leave result unchanged, issue no done pulse, set prio to the non-granted requester, and return to IDLE.
REQ-027 A request dropped after grant SHALL NOT abort the job; the job SHALL complete and its done pulse SHALL still be issued.
REQ-028 A request still high in IDLE after its done pulse SHALL be treated as a new job.
REQ-029 Latency: done SHALL be asserted N+2 rising edges after the edge that sampled the request in IDLE, where N is the number of RUN cycles including the cycle in which mul_Ready is sampled.
REQ-030 mul_Ready sampled outside RUN SHALL be ignored.
REQ-031 done0, done1 and err SHALL be mutually exclusive, and each SHALL be a single-cycle pulse.

Reset
REQ-032 When Reset=0 at a rising edge, the block SHALL go to IDLE and set prio=0, result=0, mul_A=mul_B=0, mul_Run=0, mul_Reset=0, done0=done1=err=0, busy=0, and clear the watchdog counter.
REQ-033 Reset asserted mid-job SHALL abandon the job without a done or err pulse; the first grant after release SHALL go to req0 if req0 is high.

Verification
REQ-034 Use a multiplier model that raises mul_Ready after 32 mul_Run cycles. Drive req0=1, a0=3, b0=5 -> result=15, done0 pulses once 34 edges after the request is sampled, and busy is high throughout the job.
REQ-035 After reset, drive req0=req1=1 continuously with a0=2, b0=7, a1=4, b1=9 -> completions alternate done0 (result=14), done1 (result=36), done0, with no back-to-back wins by the same requester.
REQ-036 Hold mul_Ready=0 with MAX_CYCLES=40 -> err pulses once after 40 RUN cycles, mul_Reset is high that cycle, result keeps its prior value, and neither done pulse fires.
REQ-037 Drop req1 and change a1 during RUN of a req1 job with a1=6, b1=7 -> result=42 and done1 still pulses.
REQ-038 Assert Reset=0 for one cycle in RUN -> next cycle busy=0, mul_Run=0, result=0, no done pulse; then req0 and req1 both high -> req0 is granted.
REQ-039 Use a model that raises mul_Ready exactly on RUN cycle 40 with MAX_CYCLES=40 -> DONE is taken, result is captured, and err stays 0.
